// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg : shared definitions for the push-button debouncer.
//
// Contents
//   STABLE_CYCLES_DEFAULT : stable synchronized samples needed to accept a
//                           key change (20 ms at 50 MHz)
//   CNT_WIDTH_DEFAULT     : stability counter width, 2**width > stable count
//   key_state_e           : debouncer FSM state encoding
//   is_pressed_state()    : true for the states where the key counts as held
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned CNT_WIDTH_DEFAULT     = 20;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // While waiting to confirm a release the key is still reported as held,
  // so the debounced level only drops once the release has been accepted.
  function automatic logic is_pressed_state(input key_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// ---------------------------------------------------------------------------
// key_debounce_if : groups the raw key input and the debounced outputs.
//
// Signals
//   key_n         : raw push-button, active-low, asynchronous, bouncing
//   pressed       : debounced level, 1 = key held
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//
// Modports
//   master : board / stimulus side, drives key_n and watches the results
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface key_debounce_if;

  logic key_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output key_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_n,
    output pressed,
    output press_pulse,
    output release_pulse
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous bit.
//
// Parameters
//   RESET_VAL : value both flops take during reset
// Ports
//   clk   : destination clock
//   rst_n : synchronous, active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable when d_i changes near the clock edge;
  // the second flop gives it a full cycle to settle before anyone uses it.
  // Both flops reset to the idle level so no false edge is seen after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce : debounces an active-low push-button.
//
// The raw key is synchronized, then a four-state FSM demands STABLE_CYCLES
// consecutive identical samples before accepting a press or a release.
// press_pulse is meant to drive the t input of a downstream toggle flop
// clocked by clk, so the key never has to be used as a clock itself.
//
// Parameters
//   STABLE_CYCLES : consecutive stable samples required for a change
//   CNT_WIDTH     : stability counter width, 2**CNT_WIDTH > STABLE_CYCLES
// Ports
//   clk   : board clock, all state on the rising edge
//   rst_n : synchronous, active-low reset
//   bus   : key_debounce_if slave (key_n in; pressed, press_pulse,
//           release_pulse out)
// ---------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 key_s;
  key_state_e           state_q;
  key_state_e           state_d;
  key_state_e           prevState_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 pressed_q;
  logic                 pressed_d;
  logic                 pressPulse_q;
  logic                 pressPulse_d;
  logic                 releasePulse_q;
  logic                 releasePulse_d;

  // Resets to 1 because an idle, released key reads high.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.key_n),
    .q_o   (key_s)
  );

  // State register. prevState_q remembers where we came from so the output
  // logic can spot the first cycle spent in a newly accepted state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RELEASED;
      prevState_q <= RELEASED;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prevState_q <= state_q;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic. The counter holds how many consecutive samples have
  // agreed with the pending change; any disagreeing sample is a bounce and
  // drops us back to the settled state. The counter is cleared whenever the
  // FSM sits in a settled state, so it cannot drift or wrap. The >= compare
  // is equivalent to == for any valid STABLE_CYCLES but also stops a
  // degenerate STABLE_CYCLES of 1 from counting forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  // Output decode. A pulse fires only on the first cycle in a settled state
  // reached from its wait state; a bounce back from a wait state comes from
  // the opposite wait state and therefore never pulses. The two pulses need
  // different current states, so they can never coincide.
  always_comb begin
    pressed_d      = is_pressed_state(state_q);
    pressPulse_d   = (state_q == PRESSED)  && (prevState_q == PRESS_WAIT);
    releasePulse_d = (state_q == RELEASED) && (prevState_q == RELEASE_WAIT);
  end

  // Outputs are registered so the downstream toggle flop sees clean,
  // glitch-free levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_q      <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
    end else begin
      pressed_q      <= pressed_d;
      pressPulse_q   <= pressPulse_d;
      releasePulse_q <= releasePulse_d;
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = pressPulse_q;
  assign bus.release_pulse = releasePulse_q;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000; consecutive stable synchronized samples required to accept a key change (20 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_WIDTH, default 20; stability counter width, SHALL satisfy 2**CNT_WIDTH > STABLE_CYCLES.
REQ-003 clk  input  1  board clock (50 MHz), all state on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 key_n  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk, bouncing.
REQ-006 pressed  output  1  debounced level, 1 = key held.
REQ-007 press_pulse  output  1  single-cycle strobe on accepted press; drives t of the downstream toggle flip-flop.
REQ-008 release_pulse  output  1  single-cycle strobe on accepted release.

Function
REQ-009 key_n SHALL pass through a two-flop synchronizer; only its output key_s is used by the rest of the logic.
REQ-010 FSM states SHALL be RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 RELEASED: key_s=0 -> PRESS_WAIT with counter loaded to 1; else stay, counter 0.
REQ-012 PRESS_WAIT: key_s=1 (bounce) -> RELEASED, counter 0; key_s=0 and counter=STABLE_CYCLES-1 -> PRESSED; else counter+1.
REQ-013 PRESSED: key_s=1 -> RELEASE_WAIT with counter loaded to 1; else stay, counter 0.
REQ-014 RELEASE_WAIT: key_s=0 (bounce) -> PRESSED, counter 0; key_s=1 and counter=STABLE_CYCLES-1 -> RELEASED; else counter+1.
REQ-015 pressed SHALL be 1 exactly in states PRESSED and RELEASE_WAIT (registered, no glitch).
REQ-016 press_pulse SHALL be high for exactly one cycle, the first cycle in which the state is PRESSED after PRESS_WAIT; release_pulse likewise on RELEASE_WAIT -> RELEASED.
REQ-017 Latency: for key_n falling and held stable, pressed and press_pulse SHALL rise at the clock edge STABLE_CYCLES+2 cycles after the first edge sampling key_n=0.
REQ-018 Any bounce shorter than STABLE_CYCLES samples SHALL produce no output change and no pulse.
REQ-019 press_pulse and release_pulse SHALL never be high in the same cycle; at most one pulse per accepted transition.
REQ-020 Counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-021 A key held indefinitely SHALL produce one press_pulse only (no auto-repeat).

Reset
REQ-022 While rst_n=0 at a clock edge: both synchronizer flops SHALL be set to 1 (released), state RELEASED, counter 0, pressed=0, press_pulse=0, release_pulse=0.
REQ-023 Reset asserted mid-wait or while PRESSED SHALL discard progress; no pulse SHALL be emitted in the reset cycle or the cycle after.
REQ-024 After rst_n deasserts with key already held, press SHALL be accepted normally per REQ-017 (one press_pulse).

Structure
REQ-025 State encoding constants and the STABLE_CYCLES default SHALL live in shared package key_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (reset value parameterized, here 1); all other logic in key_debounce.
REQ-027 press_pulse SHALL connect directly to the toggle flip-flop's t input, both clocked by clk, replacing direct use of KEY as a clock.

Verification (benches use STABLE_CYCLES=4)
REQ-028 key_n held 1 after reset for 20 cycles -> pressed=0, no pulses.
REQ-029 key_n 1->0 held -> press_pulse high exactly one cycle, 6 edges after first 0 sample; pressed=1 thereafter.
REQ-030 key_n toggles 0,1,0,1 at 1-cycle and 3-cycle intervals then settles 1 -> no pulses, pressed stays 0.
REQ-031 From PRESSED, key_n 0->1 held -> release_pulse one cycle after 6 edges; pressed=0; downstream T flop toggled exactly once over the press/release pair.
REQ-032 rst_n=0 for one cycle during PRESS_WAIT (counter=2) -> state RELEASED, no pulse; key still held -> press_pulse 6 edges after reset release.
REQ-033 Key held 100 cycles -> exactly one press_pulse; counter observed never above 3.
